// File: rtl/retospect_bs_loader.sv
// Configuration bitstream writer: serialises bytes LSB-first onto the fabric config chain,
// returns the displaced chain contents as readback bytes, then pulses reset_nn.
module retospect_bs_loader #(
  parameter int CHAIN_LEN = 1188,
  parameter int CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       cfg_en,
  output logic       cfg_bs,
  input  logic       chain_bs,
  output logic       rb_valid,
  output logic [7:0] rb_data,
  output logic       reset_nn_out
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int TAIL   = CHAIN_LEN % 8;
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] NBYTES_C    = CNT_W'(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NNRST, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bits_sent_q, bits_sent_d;
  logic [CNT_W-1:0] bits_issued_q, bits_issued_d;
  logic [CNT_W-1:0] bytes_acc_q, bytes_acc_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       shift_cnt_q, shift_cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             cfg_en_q, cfg_en_d;
  logic             cfg_bs_q, cfg_bs_d;
  logic [7:0]       rb_acc_q, rb_acc_d;
  logic             rb_tail_q, rb_tail_d;
  logic             rb_valid_q, rb_valid_d;
  logic [7:0]       rb_data_q, rb_data_d;
  logic             underrun_q, underrun_d;
  logic             reset_nn_q, reset_nn_d;
  logic             done_q, done_d;
  logic             accept;

  assign in_ready     = (state_q == S_LOAD) && !hold_full_q && (bytes_acc_q < NBYTES_C);
  assign accept       = in_ready && in_valid;
  assign busy         = (state_q == S_LOAD) || (state_q == S_NNRST);
  assign done         = done_q;
  assign underrun     = underrun_q;
  assign cfg_en       = cfg_en_q;
  assign cfg_bs       = cfg_bs_q;
  assign rb_valid     = rb_valid_q;
  assign rb_data      = rb_data_q;
  assign reset_nn_out = reset_nn_q;

  always_comb begin
    state_d       = state_q;
    bits_sent_d   = bits_sent_q;
    bits_issued_d = bits_issued_q;
    bytes_acc_d   = bytes_acc_q;
    shift_d       = shift_q;
    shift_cnt_d   = shift_cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    cfg_en_d      = 1'b0;
    cfg_bs_d      = 1'b0;
    rb_acc_d      = rb_acc_q;
    rb_tail_d     = rb_tail_q;
    rb_valid_d    = 1'b0;
    rb_data_d     = rb_data_q;
    underrun_d    = underrun_q;
    reset_nn_d    = 1'b0;
    done_d        = 1'b0;

    // Partial last readback byte goes out one edge after its final capture.
    if (rb_tail_q) begin
      rb_valid_d = 1'b1;
      rb_data_d  = rb_acc_q;
      rb_tail_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          bits_sent_d   = '0;
          bits_issued_d = '0;
          bytes_acc_d   = '0;
          shift_d       = '0;
          shift_cnt_d   = '0;
          hold_d        = '0;
          hold_full_d   = 1'b0;
          rb_acc_d      = '0;
          rb_tail_d     = 1'b0;
          underrun_d    = 1'b0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          hold_d      = in_data;
          hold_full_d = 1'b1;
          bytes_acc_d = bytes_acc_q + 1'b1;
        end

        // Issue side: bits beyond CHAIN_LEN in the last byte are simply never issued.
        if (bits_issued_q < CHAIN_LEN_C) begin
          if (shift_cnt_q != 4'd0) begin
            cfg_en_d      = 1'b1;
            cfg_bs_d      = shift_q[0];
            shift_d       = {1'b0, shift_q[7:1]};
            shift_cnt_d   = shift_cnt_q - 4'd1;
            bits_issued_d = bits_issued_q + 1'b1;
          end else if (hold_full_q) begin
            cfg_en_d      = 1'b1;
            cfg_bs_d      = hold_q[0];
            shift_d       = {1'b0, hold_q[7:1]};
            shift_cnt_d   = 4'd7;
            hold_full_d   = 1'b0;
            bits_issued_d = bits_issued_q + 1'b1;
          end else if (bytes_acc_q != '0) begin
            // Waiting for the very first byte is start-up latency, not starvation.
            underrun_d = 1'b1;
          end
        end

        // Fabric shifts on edges where the registered cfg_en is high.
        if (cfg_en_q) begin
          bits_sent_d                    = bits_sent_q + 1'b1;
          rb_acc_d[bits_sent_q[2:0]]     = chain_bs;
          if (bits_sent_q[2:0] == 3'd7) begin
            rb_valid_d = 1'b1;
            rb_data_d  = {chain_bs, rb_acc_q[6:0]};
            rb_acc_d   = '0;
          end else if ((TAIL != 0) && (bits_sent_q + 1'b1 == CHAIN_LEN_C)) begin
            rb_tail_d = 1'b1;
          end
          if (bits_sent_q + 1'b1 == CHAIN_LEN_C) begin
            state_d    = S_NNRST;
            reset_nn_d = 1'b1;
          end
        end
      end

      S_NNRST: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bits_sent_q   <= '0;
      bits_issued_q <= '0;
      bytes_acc_q   <= '0;
      shift_q       <= '0;
      shift_cnt_q   <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      cfg_en_q      <= 1'b0;
      cfg_bs_q      <= 1'b0;
      rb_acc_q      <= '0;
      rb_tail_q     <= 1'b0;
      rb_valid_q    <= 1'b0;
      rb_data_q     <= '0;
      underrun_q    <= 1'b0;
      reset_nn_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bits_sent_q   <= bits_sent_d;
      bits_issued_q <= bits_issued_d;
      bytes_acc_q   <= bytes_acc_d;
      shift_q       <= shift_d;
      shift_cnt_q   <= shift_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      cfg_en_q      <= cfg_en_d;
      cfg_bs_q      <= cfg_bs_d;
      rb_acc_q      <= rb_acc_d;
      rb_tail_q     <= rb_tail_d;
      rb_valid_q    <= rb_valid_d;
      rb_data_q     <= rb_data_d;
      underrun_q    <= underrun_d;
      reset_nn_q    <= reset_nn_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: doc/retospect_bs_loader.md
# retospect_bs_loader

On-chip configuration bitstream writer for the neurochip fabric. It accepts configuration bytes over a valid/ready byte stream and serialises them LSB-first onto the fabric's config chain (`config_en` / `bs_in`). At the same time it captures the chain's `bs_out` and returns the displaced old contents as readback bytes. When the load completes, it issues a one-cycle `reset_nn` pulse so the newly configured neurons start from their initial state.

## Interface
Parameters:
- CHAIN_LEN, 1188: total config chain bits (clockbox 48 + 60 cells × 19).
- CNT_W, 11: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low; clears all state.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- busy  out  1  high in LOAD and NNRST.
- done  out  1  one-cycle pulse when the load sequence completes.
- underrun  out  1  sticky; set on any starved shift slot; cleared by an accepted start.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte; bit 0 is shifted first.
- in_ready  out  1  byte accepted on an edge where in_valid && in_ready.
- cfg_en  out  1  registered; drives fabric config_en.
- cfg_bs  out  1  registered; drives fabric bs_in.
- chain_bs  in  1  fabric bs_out (tail of chain).
- rb_valid  out  1  one-cycle pulse; rb_data valid.
- rb_data  out  8  readback byte; first captured bit in bit 0.
- reset_nn_out  out  1  registered; drives fabric reset_nn.

## Operation
- States: IDLE, LOAD, NNRST, DONE.
- IDLE → LOAD on start. Entering LOAD clears the bit counter, byte counter, buffers, readback accumulator and underrun.
- Buffering is two-entry: a shift byte plus a holding byte.
  - in_ready = (state==LOAD) && holding empty && bytes_accepted < ceil(CHAIN_LEN/8).
  - An accepted byte enters the holding register.
  - When the shift byte is exhausted, the holding byte moves into it on the same edge it would otherwise starve.
- Shift slot: on each LOAD edge with bits_sent < CHAIN_LEN:
  - If a bit is available, register cfg_en=1 and cfg_bs=next bit.
  - If no bit is available, register cfg_en=0 and set underrun. Bits are never dropped or duplicated.
- Bit counting: bits_sent increments on every edge where registered cfg_en==1, which is the fabric's shift edge.
- Readback capture: on the same edges, chain_bs (the pre-shift value) is captured into the readback accumulator at position (bits_sent mod 8).
  - Every 8th captured bit, pulse rb_valid with the completed byte.
- Final byte: only the low (CHAIN_LEN mod 8) bits are shifted and the rest are discarded. If CHAIN_LEN mod 8 = 0, the whole byte is used.
  - The last partial readback byte is emitted zero-padded in the upper bits on the edge after its final capture.
- LOAD → NNRST after the edge where bits_sent reaches CHAIN_LEN. cfg_en is 0 from that cycle onward.
- NNRST: reset_nn_out=1 for exactly one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is never accepted.
- Reset values: all outputs 0, state IDLE, underrun 0.
- Asserting rst_n low mid-load forces cfg_en, cfg_bs, reset_nn_out, in_ready, rb_valid, busy and done to 0 immediately (asynchronous). The fabric chain is left partially loaded, and a fresh start is required.

## Timing
- Latency from start to the first cfg_en=1:
  - 1 cycle to LOAD.
  - The byte is accepted on the first LOAD edge.
  - cfg_en is registered on the following edge. With in_valid held high, the first cfg_en appears 3 edges after start.
- With a continuous supply (in_valid held high), cfg_en is contiguous for exactly CHAIN_LEN cycles. The holding byte must refill at least once per 8 cycles.
- reset_nn_out is asserted 1 cycle after the last cfg_en cycle. done follows reset_nn_out by 1 cycle.
- A full load takes CHAIN_LEN + ~5 cycles.
- Fabric constraint: while cfg_en=0 the fabric runs neuron dynamics. An underrun therefore may corrupt partially loaded uT values, and the host must reload if underrun=1 at done.

## Test plan
- Reset: hold rst_n=0 → all outputs 0. Release and hold for 10 idle cycles → no cfg_en, in_ready=0.
- Contiguous load, CHAIN_LEN=20, bytes 0xA5, 0x3C, 0x0F:
  - cfg_bs sequence = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1 over 20 contiguous cfg_en cycles.
  - Exactly 3 bytes accepted.
  - reset_nn_out is 1 for one cycle, then done pulses; underrun=0.
- Readback, CHAIN_LEN=20, chain model preloaded with 20-bit pattern 0x5A5A5 (bit 0 at tail) → rb_data 0xA5, 0xA5, then 0x05.
- Underrun: drop in_valid for 12 cycles mid-load → cfg_en gaps, underrun=1 at done. Total cfg_en cycles is still 20 and the bit order is unchanged.
- Async reset at bit 10 → outputs 0 within the same cycle, state IDLE. A fresh start then completes a full, correct load.
- Protocol guards:
  - start pulsed while busy → no effect.
  - in_valid in IDLE → in_ready stays 0.
  - A 4th byte offered at CHAIN_LEN=20 → not accepted.
